// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared address map, status bit layout and event-status helpers for the input responder
package io_pkg;

  localparam logic [31:0] ADDR_KEY   = 32'hF000_0010;
  localparam logic [31:0] ADDR_SW    = 32'hF000_0014;
  localparam logic [31:0] ADDR_KCTRL = 32'hF000_0110;
  localparam logic [31:0] ADDR_SCTRL = 32'hF000_0114;

  localparam int CTRL_READY_BIT   = 0;
  localparam int CTRL_OVERRUN_BIT = 2;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

  typedef struct packed {
    logic overrun;
    logic ready;
  } evt_status_t;

  // A change always wins over a concurrent data read or overrun clear.
  function automatic evt_status_t next_status(input evt_status_t cur, input logic change,
                                              input logic rd_data, input logic clr_ovr);
    evt_status_t nxt;
    nxt.ready   = change | (cur.ready & ~rd_data);
    nxt.overrun = (change & cur.ready & ~rd_data) | (cur.overrun & ~clr_ovr);
    return nxt;
  endfunction

  function automatic logic [31:0] ctrl_word(input evt_status_t st);
    logic [31:0] w;
    w = '0;
    w[CTRL_READY_BIT]   = st.ready;
    w[CTRL_OVERRUN_BIT] = st.overrun;
    return w;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - two-flop synchroniser plus stable-count debouncer for one raw input bit
module debounce_bit
  import io_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_toggle
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          w_differs;
  logic          w_toggle;

  assign w_differs = (r_sync2 != r_level);
  // Toggle on the DEBOUNCE_CYCLES-th consecutive mismatching cycle.
  assign w_toggle  = w_differs && (r_cnt == LAST_COUNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= RESET_LEVEL;
      r_sync2 <= RESET_LEVEL;
      r_level <= RESET_LEVEL;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (w_toggle) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level  = r_level;
  assign o_toggle = w_toggle;

endmodule

// File: rtl/io_input_responder.sv
// rtl/io_input_responder.sv - memory-mapped KEY/SW responder with debounced data and sticky ready/overrun status
module io_input_responder
  import io_pkg::*;
#(
  parameter int DBITS           = 32,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  input  logic [DBITS-1:0] addr,
  input  logic             rdEn,
  input  logic             wrEn,
  input  logic [DBITS-1:0] wrData,
  output logic [DBITS-1:0] rdData,
  output logic             hit
);

  logic [3:0]  w_key_deb;
  logic [3:0]  w_key_tog;
  logic [9:0]  w_sw_deb;
  logic [9:0]  w_sw_tog;

  for (genvar gi = 0; gi < 4; gi++) begin : g_key
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (1'b1)
    ) u_deb (
      .clk     (clk),
      .reset   (reset),
      .i_raw   (KEY[gi]),
      .o_level (w_key_deb[gi]),
      .o_toggle(w_key_tog[gi])
    );
  end

  for (genvar gi = 0; gi < 10; gi++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (1'b0)
    ) u_deb (
      .clk     (clk),
      .reset   (reset),
      .i_raw   (SW[gi]),
      .o_level (w_sw_deb[gi]),
      .o_toggle(w_sw_tog[gi])
    );
  end

  logic w_sel_kdata;
  logic w_sel_sdata;
  logic w_sel_kctrl;
  logic w_sel_sctrl;

  assign w_sel_kdata = (addr == DBITS'(ADDR_KEY));
  assign w_sel_sdata = (addr == DBITS'(ADDR_SW));
  assign w_sel_kctrl = (addr == DBITS'(ADDR_KCTRL));
  assign w_sel_sctrl = (addr == DBITS'(ADDR_SCTRL));

  logic w_k_change;
  logic w_s_change;
  logic w_read_k;
  logic w_read_s;
  logic w_clr_k;
  logic w_clr_s;

  assign w_k_change = |w_key_tog;
  assign w_s_change = |w_sw_tog;
  assign w_read_k   = rdEn & w_sel_kdata;
  assign w_read_s   = rdEn & w_sel_sdata;
  // Only a 0 in the overrun bit clears; every other write bit is ignored.
  assign w_clr_k    = wrEn & w_sel_kctrl & ~wrData[CTRL_OVERRUN_BIT];
  assign w_clr_s    = wrEn & w_sel_sctrl & ~wrData[CTRL_OVERRUN_BIT];

  logic w_unused_wrdata;
  assign w_unused_wrdata = ^{wrData[DBITS-1:CTRL_OVERRUN_BIT+1], wrData[CTRL_OVERRUN_BIT-1:0]};

  evt_status_t r_k_stat;
  evt_status_t r_s_stat;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_k_stat <= '0;
      r_s_stat <= '0;
    end else begin
      r_k_stat <= next_status(r_k_stat, w_k_change, w_read_k, w_clr_k);
      r_s_stat <= next_status(r_s_stat, w_s_change, w_read_s, w_clr_s);
    end
  end

  logic [31:0] w_rd_word;

  always_comb begin
    w_rd_word = '0;
    if (w_sel_kdata)      w_rd_word = {28'b0, ~w_key_deb};
    else if (w_sel_sdata) w_rd_word = {22'b0, w_sw_deb};
    else if (w_sel_kctrl) w_rd_word = ctrl_word(r_k_stat);
    else if (w_sel_sctrl) w_rd_word = ctrl_word(r_s_stat);
  end

  assign rdData = DBITS'(w_rd_word);
  assign hit    = w_sel_kdata | w_sel_sdata | w_sel_kctrl | w_sel_sctrl;

endmodule

// File: tb/tb_io_input_responder.sv
// tb/tb_io_input_responder.sv - directed self-checking bench for io_input_responder with a 4-cycle debounce
module tb_io_input_responder;

  localparam int DB = 4;
  localparam logic [31:0] A_KEY   = 32'hF000_0010;
  localparam logic [31:0] A_SW    = 32'hF000_0014;
  localparam logic [31:0] A_KCTRL = 32'hF000_0110;
  localparam logic [31:0] A_SCTRL = 32'hF000_0114;
  localparam logic [31:0] A_MISS  = 32'hF000_0018;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  KEY;
  logic [9:0]  SW;
  logic [31:0] addr;
  logic        rdEn;
  logic        wrEn;
  logic [31:0] wrData;
  logic [31:0] rdData;
  logic        hit;

  int checks = 0;
  int errors = 0;

  io_input_responder #(
    .DBITS          (32),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .KEY   (KEY),
    .SW    (SW),
    .addr  (addr),
    .rdEn  (rdEn),
    .wrEn  (wrEn),
    .wrData(wrData),
    .rdData(rdData),
    .hit   (hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rdData, exp);
  endtask

  task automatic rd_strobe(input logic [31:0] a);
    addr = a;
    rdEn = 1'b1;
    cyc(1);
    rdEn = 1'b0;
  endtask

  task automatic wr_strobe(input logic [31:0] a, input logic [31:0] d);
    addr   = a;
    wrData = d;
    wrEn   = 1'b1;
    cyc(1);
    wrEn   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; KEY = 4'hF; SW = 10'h000;
    addr = '0; rdEn = 1'b0; wrEn = 1'b0; wrData = '0;
    cyc(3);
    reset = 1'b0;
    cyc(2);

    // reset state and address decode
    peek("rst_kdata", A_KEY, 32'h0);   check("hit_kdata", {31'b0, hit}, 32'h1);
    peek("rst_sdata", A_SW, 32'h0);    check("hit_sdata", {31'b0, hit}, 32'h1);
    peek("rst_kctrl", A_KCTRL, 32'h0); check("hit_kctrl", {31'b0, hit}, 32'h1);
    peek("rst_sctrl", A_SCTRL, 32'h0); check("hit_sctrl", {31'b0, hit}, 32'h1);
    peek("miss_data", A_MISS, 32'h0);  check("miss_hit", {31'b0, hit}, 32'h0);

    // KEY[1] press: visible exactly 2+DB cycles later
    cyc(1);
    KEY = 4'hD;
    cyc(5);
    peek("key_lat5", A_KEY, 32'h0);
    cyc(1);
    peek("key_lat6", A_KEY, 32'h2);
    peek("kctrl_rdy", A_KCTRL, 32'h1);
    rd_strobe(A_KEY);
    peek("kctrl_rd", A_KCTRL, 32'h0);

    // 3-cycle glitch on KEY[0] is rejected
    KEY = 4'hC;
    cyc(3);
    KEY = 4'hD;
    cyc(10);
    peek("glitch_kd", A_KEY, 32'h2);
    peek("glitch_kc", A_KCTRL, 32'h0);

    // SW overrun, ignored set-write, clear, read
    SW = 10'h3FF;
    cyc(8);
    SW = 10'h000;
    cyc(8);
    peek("sw_data", A_SW, 32'h0);
    peek("sctrl_ovr", A_SCTRL, 32'h5);
    wr_strobe(A_SCTRL, 32'h4);
    peek("sctrl_w4", A_SCTRL, 32'h5);
    wr_strobe(A_SW, 32'h0);
    peek("sctrl_wsd", A_SCTRL, 32'h5);
    wr_strobe(A_SCTRL, 32'h0);
    peek("sctrl_clr", A_SCTRL, 32'h1);
    rd_strobe(A_SW);
    peek("sctrl_rd", A_SCTRL, 32'h0);

    // read of KDATA coinciding with a debounced toggle
    KEY = 4'h9;
    cyc(8);
    peek("k2_data", A_KEY, 32'h6);
    peek("k2_ctrl", A_KCTRL, 32'h1);
    KEY = 4'hD;
    cyc(5);
    rd_strobe(A_KEY);
    peek("rdtog_ctrl", A_KCTRL, 32'h1);
    peek("rdtog_data", A_KEY, 32'h2);

    // overrun clear coinciding with a new overrun event
    KEY = 4'h5;
    cyc(8);
    peek("k3_data", A_KEY, 32'hA);
    peek("k3_ovr", A_KCTRL, 32'h5);
    KEY = 4'hD;
    cyc(5);
    wr_strobe(A_KCTRL, 32'h0);
    peek("clrset_ctrl", A_KCTRL, 32'h5);
    wr_strobe(A_KCTRL, 32'h0);
    peek("clr_ctrl", A_KCTRL, 32'h1);

    KEY = 4'hF;
    cyc(10);
    rd_strobe(A_KEY);

    // reset mid-debounce discards the partial count on SW[5]
    SW = 10'h020;
    cyc(4);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(5);
    peek("rstmid_sd", A_SW, 32'h0);
    peek("rstmid_sc", A_SCTRL, 32'h0);
    cyc(1);
    peek("rstmid_sd2", A_SW, 32'h20);
    peek("rstmid_sc2", A_SCTRL, 32'h1);
    peek("rstmid_miss", A_MISS, 32'h0);
    check("rstmid_hit", {31'b0, hit}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
